cpu_punt_arb: RTL and testbench
===============================

# cpu_punt_arb

Frame-aware round-robin arbiter that merges the punt streams from the data-plane stages into the single to-CPU stream. Its output feeds the CPU-bound 128-bit frame FIFO that the CPU drains through CSRs. Frames are never interleaved. Each granted input keeps the grant until its `tlast` beat is accepted. Per-input frame counters support CPU-side diagnostics.

## Interface
Parameters:
- `N_IN`, 2: number of punt sources (2..8).
- `DATA_WIDTH`, 128: tdata width.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `USER_WIDTH`, 8: tuser width ({bypass_all, bypass_stage, src, dst}, passed through opaque).

Ports:
- `clk`  in  1: single clock. Reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high reset.
- `s_tdata`  in  `N_IN*DATA_WIDTH`: input i occupies slice i.
- `s_tkeep`  in  `N_IN*KEEP_WIDTH`.
- `s_tuser`  in  `N_IN*USER_WIDTH`.
- `s_tlast`  in  `N_IN`.
- `s_tvalid`  in  `N_IN`.
- `s_tready`  out  `N_IN`.
- `m_tdata`  out  `DATA_WIDTH`.
- `m_tkeep`  out  `KEEP_WIDTH`.
- `m_tuser`  out  `USER_WIDTH`.
- `m_tlast`  out  1.
- `m_tvalid`  out  1.
- `m_tready`  in  1.
- `status_busy`  out  1: a frame is in progress (state PASS).
- `status_grant`  out  `$clog2(N_IN)`: currently or last granted input.
- `status_frames`  out  `N_IN*16`: per-input count of accepted `tlast` beats, wrapping.

## Operation
- **FSM states:** ARB and PASS.
- **ARB:**
  - If any `s_tvalid` is set, select the first asserted input searching from `last_grant+1` modulo `N_IN`.
  - Register `grant` and go to PASS.
  - All `s_tready` are 0 in ARB.
- **PASS:**
  - `s_tready[grant]` = skid-buffer ready. All other `s_tready` are 0.
  - Beats of input `grant` pass to the output unchanged: tdata, tkeep, tuser, tlast.
  - An accepted beat with `s_tlast` returns the FSM to ARB and sets `last_grant` = `grant`.
- **Input bubbles:** an idle cycle (`s_tvalid[grant]`=0) mid-frame keeps the grant. There is no timeout.
- **Single-beat frames:** a frame that is a single beat with `tlast` is legal. The FSM goes ARB→PASS→ARB.
- **Counters:** `status_frames[i]` increments on `s_tvalid[i] & s_tready[i] & s_tlast[i]` and wraps from 0xFFFF to 0.
- **No modification:** the block never drops, reorders or modifies beats. Full/overflow policy belongs to the downstream frame FIFO.
- **Output stage:** a 2-entry skid buffer. `m_*` are driven from registers. Ready is registered.

## Timing
- **Reset values:**
  - `m_tvalid`=0, `m_tdata`/`m_tkeep`/`m_tuser`/`m_tlast`=0.
  - `s_tready`=0, `status_busy`=0.
  - `status_grant`=0, `last_grant`=`N_IN-1` (so input 0 wins first), `status_frames`=0.
  - FSM=ARB.
- **Latency:** a beat accepted at input edge n appears on `m_*` after edge n (1 cycle).
- **Throughput:** 1 beat/cycle inside a frame while `m_tready`=1. There is exactly one ARB bubble cycle between consecutive frames.
- **Backpressure:** `m_tready` low for k cycles lets at most 2 beats accumulate. `s_tready[grant]` drops by the cycle after the skid fills. No beat is lost or duplicated.
- **AXIS rules:** `m_tvalid` is never deasserted and `m_*` never change while `m_tvalid`=1 and `m_tready`=0.
- **Simultaneous requests:** strict rotation. With all inputs continuously valid, the grants run 0,1,..,N_IN-1,0.
- **Reset mid-frame:** the skid buffer is flushed and the grant released. The partial frame is discarded by this block. The downstream FIFO shares `rst`, so it is reset in the same cycle.

## Structure
- The shared data-plane package holds:
  - the tuser struct typedef (bypass_all, bypass_stage, src, dst) and its width constant;
  - `DPE_DATA_WIDTH`=128.
- The FSM state enum is local to the module.
- Sub-module: `axis_skid`, a 2-entry register slice with registered ready, parameterised by payload width. It is reusable elsewhere in the data plane.

## Test plan
- **Reset:** hold `rst` for 3 cycles with all `s_tvalid`=1. Required: all outputs at their reset values, `s_tready`=0. Input 0 is granted first after release.
- **Round-robin:** `N_IN`=2, both inputs continuously present 3-beat frames (tdata 0xA0.., 0xB0..). Required: output frames alternate A,B,A,B with no interleaving, one bubble between frames, and `status_frames` = {2,2} after 4 frames.
- **Backpressure:** random `m_tready` (50%) on a 10-beat frame with tkeep=0x00FF on the last beat. Required: all 10 beats are delivered in order, the last has tkeep 0x00FF and tlast=1, and no `m_*` change while stalled.
- **Source bubble:** input 1 deasserts tvalid for 4 cycles mid-frame while input 0 is valid. Required: the grant stays on 1, and input 0 waits until input 1's tlast.
- **Single-beat and wrap:** input 0 sends 65537 single-beat frames. Required: `status_frames[0]` = 1 (wrapped), and the output beat count is 65537.
- **Reset mid-frame:** assert `rst` after beat 2 of a 5-beat frame. Required: `m_tvalid`=0 the next cycle, state ARB, and the next frame starts cleanly from input 0.

Source files
------------

// File: rtl/cpu_punt_arb_pkg.sv
// Shared data-plane definitions: beat widths and the tuser sideband layout.
package cpu_punt_arb_pkg;

    localparam int DPE_DATA_WIDTH = 128;

    typedef struct packed {
        logic       bypass_all;
        logic       bypass_stage;
        logic [2:0] src;
        logic [2:0] dst;
    } dpe_tuser_t;

    localparam int DPE_USER_WIDTH = $bits(dpe_tuser_t);

endpackage

// File: rtl/cpu_punt_arb_skid.sv
// axis_skid: 2-entry AXI-stream register slice; outputs and ready both come
// straight from flops so neither path is combinational through the slice.
module axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    // Ready is simply "second entry free", so it is a flop output.
    assign s_ready = ~skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!skid_valid) begin
            if (m_ready || !m_valid) begin
                m_valid <= s_valid;
                if (s_valid) m_data <= s_data;
            end else if (s_valid) begin
                skid_data  <= s_data;
                skid_valid <= 1'b1;
            end
        end else if (m_ready) begin
            m_data     <= skid_data;
            skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_punt_arb.sv
// Frame-aware round-robin merge of the data-plane punt streams into the
// single to-CPU stream; a granted input holds the grant until its tlast.
module cpu_punt_arb
    import cpu_punt_arb_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int DATA_WIDTH = DPE_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = DPE_USER_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_IN*DATA_WIDTH-1:0]   s_tdata,
    input  logic [N_IN*KEEP_WIDTH-1:0]   s_tkeep,
    input  logic [N_IN*USER_WIDTH-1:0]   s_tuser,
    input  logic [N_IN-1:0]              s_tlast,
    input  logic [N_IN-1:0]              s_tvalid,
    output logic [N_IN-1:0]              s_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [KEEP_WIDTH-1:0]        m_tkeep,
    output logic [USER_WIDTH-1:0]        m_tuser,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         status_busy,
    output logic [$clog2(N_IN)-1:0]      status_grant,
    output logic [N_IN*16-1:0]           status_frames
);

    localparam int GW = $clog2(N_IN);
    localparam int PW = 1 + USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

    typedef enum logic {ARB, PASS} state_t;

    state_t                 state, state_nxt;
    logic [GW-1:0]          grant, grant_nxt, last_grant, last_grant_nxt;
    logic [GW-1:0]          pick, cand;
    logic                   found;
    logic                   skid_ready, in_valid, in_fire;
    logic [PW-1:0]          in_payload, out_payload;
    logic [N_IN-1:0][15:0]  frames;

    // Rotating priority: search starts one past the last frame's owner.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_IN; k++) begin
            cand = GW'((int'(last_grant) + k) % N_IN);
            if (!found && s_tvalid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign in_valid   = (state == PASS) && s_tvalid[grant];
    assign in_fire    = in_valid && skid_ready;
    assign in_payload = {s_tlast[grant],
                         s_tuser[grant*USER_WIDTH +: USER_WIDTH],
                         s_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH],
                         s_tdata[grant*DATA_WIDTH +: DATA_WIDTH]};

    always_comb begin
        s_tready = '0;
        if (state == PASS) s_tready[grant] = skid_ready;
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            ARB: if (|s_tvalid) begin
                grant_nxt = pick;
                state_nxt = PASS;
            end
            PASS: if (in_fire && s_tlast[grant]) begin
                last_grant_nxt = grant;
                state_nxt      = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= GW'(N_IN - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++)
                if (s_tvalid[i] && s_tready[i] && s_tlast[i]) frames[i] <= frames[i] + 16'd1;
        end
    end

    axis_skid #(.WIDTH(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  (in_payload),
        .s_valid (in_valid),
        .s_ready (skid_ready),
        .m_data  (out_payload),
        .m_valid (m_tvalid),
        .m_ready (m_tready)
    );

    assign {m_tlast, m_tuser, m_tkeep, m_tdata} = out_payload;
    assign status_busy   = (state == PASS);
    assign status_grant  = grant;
    assign status_frames = frames;

endmodule

// File: tb/tb_cpu_punt_arb.sv
// Directed bench for cpu_punt_arb: reset, rotation, backpressure, source
// bubbles, single-beat counter wrap and reset in the middle of a frame.
module tb_cpu_punt_arb;

    localparam int N  = 2;
    localparam int DW = 128;
    localparam int KW = 16;
    localparam int UW = 8;
    localparam int BW = 1 + UW + KW + DW;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            idle;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N*DW-1:0]      s_tdata;
    logic [N*KW-1:0]      s_tkeep;
    logic [N*UW-1:0]      s_tuser;
    logic [N-1:0]         s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]        m_tdata;
    logic [KW-1:0]        m_tkeep;
    logic [UW-1:0]        m_tuser;
    logic                 m_tlast, m_tvalid, m_tready;
    logic                 status_busy;
    logic [$clog2(N)-1:0] status_grant;
    logic [N*16-1:0]      status_frames;

    always #5 clk = ~clk;

    cpu_punt_arb #(.N_IN(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
        .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .status_busy(status_busy), .status_grant(status_grant),
        .status_frames(status_frames)
    );

    int            total = 0, bad = 0, cyc = 0, first_acc = -1, stall_bad = 0;
    beat_t         src_q[N][$];
    logic [BW-1:0] exp_q[$], out_q[$];
    int            out_cyc[$];
    int            idle_left[N];
    bit            loaded[N];
    int            in_cnt[N];
    logic          acc[N];
    bit            rdy_rand = 0, prev_stall = 0;
    logic [BW-1:0] prev_bus, cur_bus;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BW-1:0] pk(input beat_t b);
        return {b.last, b.user, b.keep, b.data};
    endfunction

    task automatic add_frame(input int src, input logic [7:0] tag, input int n,
                             input logic [KW-1:0] last_keep, input int idle_at,
                             input int idle_n, input bit to_exp);
        for (int b = 0; b < n; b++) begin
            beat_t bt;
            bt.data = {tag, 88'h0, 8'(src), 16'(b), 8'(n)};
            bt.keep = (b == n - 1) ? last_keep : '1;
            bt.user = {2'b00, 3'(src), 3'd0};
            bt.last = (b == n - 1);
            bt.idle = (b == idle_at) ? idle_n : 0;
            src_q[src].push_back(bt);
            if (to_exp) exp_q.push_back(pk(bt));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = 1'b0;
            s_tlast[i]           = 1'b0;
            s_tdata[i*DW +: DW]  = '0;
            s_tkeep[i*KW +: KW]  = '0;
            s_tuser[i*UW +: UW]  = '0;
            if (src_q[i].size() > 0) begin
                if (!loaded[i]) begin
                    idle_left[i] = src_q[i][0].idle;
                    loaded[i]    = 1'b1;
                end
                if (idle_left[i] > 0) begin
                    idle_left[i]--;
                end else begin
                    s_tvalid[i]         = 1'b1;
                    s_tlast[i]          = src_q[i][0].last;
                    s_tdata[i*DW +: DW] = src_q[i][0].data;
                    s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                    s_tuser[i*UW +: UW] = src_q[i][0].user;
                end
            end
        end
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: observe at the falling edge, apply new inputs 1 unit after the rise.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) acc[i] = s_tvalid[i] & s_tready[i] & ~rst;
        cur_bus = {m_tlast, m_tuser, m_tkeep, m_tdata};
        if (!rst && m_tvalid && m_tready) begin
            out_q.push_back(cur_bus);
            out_cyc.push_back(cyc);
        end
        if (!rst && prev_stall && (!m_tvalid || cur_bus !== prev_bus)) stall_bad++;
        prev_stall = !rst && m_tvalid && !m_tready;
        prev_bus   = cur_bus;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                loaded[i] = 1'b0;
                in_cnt[i]++;
                if (first_acc < 0) first_acc = cyc;
            end
        end
        drive();
    endtask

    task automatic run(input string tag, input int budget);
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size() != 0 || m_tvalid) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 256'(n < budget), 256'(1));
    endtask

    task automatic verify(input string tag);
        check({tag, "_count"}, 256'(out_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 256'(out_q[i]), 256'(exp_q[i]));
    endtask

    task automatic clear_obs();
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
        first_acc = -1;
        stall_bad = 0;
        for (int i = 0; i < N; i++) in_cnt[i] = 0;
    endtask

    initial begin
        int nb;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin loaded[i] = 1'b0; idle_left[i] = 0; in_cnt[i] = 0; end

        // Reset with every input valid; expected output order is A0,B0,A1,B1.
        add_frame(0, 8'hA0, 3, '1, -1, 0, 1);
        add_frame(1, 8'hB0, 3, '1, -1, 0, 1);
        add_frame(0, 8'hA1, 3, '1, -1, 0, 1);
        add_frame(1, 8'hB1, 3, '1, -1, 0, 1);
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_m_tvalid", 256'(m_tvalid), 256'(0));
            check("rst_m_bus", 256'({m_tlast, m_tuser, m_tkeep, m_tdata}), 256'(0));
            check("rst_s_tready", 256'(s_tready), 256'(0));
            check("rst_busy", 256'(status_busy), 256'(0));
            check("rst_grant", 256'(status_grant), 256'(0));
            check("rst_frames", 256'(status_frames), 256'(0));
        end
        rst = 1'b0;
        first_acc = -1;
        run("rr", 100);
        verify("rr");
        if (out_cyc.size() == 12) begin
            check("rr_latency", 256'(out_cyc[0]), 256'(first_acc + 1));
            for (int i = 1; i < 12; i++)
                check($sformatf("rr_gap%0d", i), 256'(out_cyc[i] - out_cyc[i-1]), 256'((i % 3 == 0) ? 2 : 1));
        end
        check("rr_frames", 256'(status_frames), 256'(32'h0002_0002));

        // Random output backpressure on a 10-beat frame with a partial last beat.
        clear_obs();
        add_frame(0, 8'hC0, 10, 16'h00FF, -1, 0, 1);
        rdy_rand = 1;
        run("bp", 300);
        rdy_rand = 0;
        verify("bp");
        check("bp_stall_stable", 256'(stall_bad), 256'(0));
        check("bp_frames", 256'(status_frames), 256'(32'h0002_0003));

        // Input 1 goes idle for 4 cycles mid-frame; input 0 must wait.
        clear_obs();
        add_frame(1, 8'hD1, 5, '1, 2, 4, 1);
        add_frame(0, 8'hD0, 2, '1, -1, 0, 1);
        nb = 0;
        for (int n = 0; n < 60 && (src_q[0].size() + src_q[1].size() != 0 || m_tvalid); n++) begin
            step();
            if (src_q[1].size() > 0 && !s_tvalid[1]) begin
                nb++;
                check("bub_grant", 256'(status_grant), 256'(1));
                check("bub_busy", 256'(status_busy), 256'(1));
                check("bub_tready0", 256'(s_tready[0]), 256'(0));
            end
        end
        check("bub_cycles", 256'(nb), 256'(4));
        verify("bub");

        // 65537 single-beat frames from input 0 after a fresh reset.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_obs();
        for (int f = 0; f < 65537; f++) add_frame(0, 8'hE0, 1, '1, -1, 0, 0);
        run("wrap", 140000);
        check("wrap_out_count", 256'(out_q.size()), 256'(65537));
        check("wrap_frames", 256'(status_frames), 256'(32'h0000_0001));

        // Reset two beats into a 5-beat frame from input 1.
        clear_obs();
        add_frame(1, 8'hF1, 5, '1, -1, 0, 0);
        for (int n = 0; n < 20 && in_cnt[1] < 2; n++) step();
        check("mf_two_beats", 256'(in_cnt[1]), 256'(2));
        check("mf_busy_before", 256'(status_busy), 256'(1));
        rst = 1'b1;
        src_q[0].delete();
        src_q[1].delete();
        for (int i = 0; i < N; i++) loaded[i] = 1'b0;
        drive();
        step();
        check("mf_m_tvalid", 256'(m_tvalid), 256'(0));
        check("mf_busy", 256'(status_busy), 256'(0));
        check("mf_s_tready", 256'(s_tready), 256'(0));
        check("mf_frames", 256'(status_frames), 256'(0));
        rst = 1'b0;
        clear_obs();
        add_frame(0, 8'hF0, 3, '1, -1, 0, 1);
        add_frame(1, 8'hF2, 3, '1, -1, 0, 1);
        run("mf", 100);
        verify("mf");
        check("mf_frames_after", 256'(status_frames), 256'(32'h0001_0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
